// File: rtl/bcd_stopwatch_ctl.sv
// BCD stopwatch/timer MM:SS.cc with up/down count, preset load and pause.
// Optional lap capture registers are built when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_ctl #(
    parameter int TICK_DIV     = 500000,
    parameter int DIV_W        = 20,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        PAUSE,
    input  logic        DOWN,
    input  logic        LOAD,
    input  logic [23:0] PRESET,
    output logic [3:0]  MSH,
    output logic [3:0]  MSL,
    output logic [3:0]  SH,
    output logic [3:0]  SL,
    output logic [3:0]  MH,
    output logic [3:0]  ML,
    output logic        TICK,
    output logic        WRAP,
    output logic        ZERO,
    output logic        DONE
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic        LAP,
    output logic [3:0]  LAP_MSH,
    output logic [3:0]  LAP_MSL,
    output logic [3:0]  LAP_SH,
    output logic [3:0]  LAP_SL,
    output logic [3:0]  LAP_MH,
    output logic [3:0]  LAP_ML,
    output logic        LAP_VALID
`endif
);

    // Digit vector layout, low to high nibble: MSL, MSH, SL, SH, ML, MH.
    logic [23:0]      digit_reg, digit_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;
    logic             wrap_reg, wrap_next;
    logic             done_reg, done_next;

    logic [23:0] up_val;
    logic [23:0] dn_val;
    logic [23:0] preset_clamped;
    logic [5:0]  at_max;
    logic [5:0]  at_min;
    logic [6:0]  carry;
    logic [5:0]  borrow;

    logic advance;
    logic at_term;
    logic step;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] DMAX = (gi == 3) ? 4'd5 :
                                          (gi == 5) ? 4'(MIN_TENS_MAX) : 4'd9;
            logic [3:0] cur;
            logic [3:0] pre;

            assign cur = digit_reg[4*gi +: 4];
            assign pre = PRESET[4*gi +: 4];

            assign at_max[gi] = (cur == DMAX);
            assign at_min[gi] = (cur == 4'd0);

            assign up_val[4*gi +: 4] = carry[gi]  ? (at_max[gi] ? 4'd0 : cur + 4'd1) : cur;
            assign dn_val[4*gi +: 4] = borrow[gi] ? (at_min[gi] ? DMAX : cur - 4'd1) : cur;

            assign preset_clamped[4*gi +: 4] = (pre > DMAX) ? DMAX : pre;

            // Chains are flattened so no signal feeds back into itself.
            assign carry[gi+1] = &at_max[gi:0];
            if (gi < 5) begin : g_borrow
                assign borrow[gi+1] = &at_min[gi:0];
            end
        end
    endgenerate

    assign ZERO    = (digit_reg == 24'd0);
    assign advance = !PAUSE && !LOAD && !(DOWN && ZERO);
    assign at_term = (div_reg == DIV_W'(TICK_DIV - 1));
    assign step    = advance && at_term;

    always_comb begin
        digit_next = digit_reg;
        div_next   = div_reg;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        done_next  = done_reg;
        if (LOAD) begin
            digit_next = preset_clamped;
            div_next   = '0;
            done_next  = 1'b0;
        end else if (step) begin
            div_next  = '0;
            tick_next = 1'b1;
            if (DOWN) begin
                digit_next = dn_val;
                if (dn_val == 24'd0) begin
                    done_next = 1'b1;
                end
            end else begin
                digit_next = up_val;
                wrap_next  = carry[6];
            end
        end else if (advance) begin
            div_next = div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            digit_reg <= '0;
            div_reg   <= '0;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            digit_reg <= digit_next;
            div_reg   <= div_next;
            tick_reg  <= tick_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
        end
    end

    assign MSL  = digit_reg[3:0];
    assign MSH  = digit_reg[7:4];
    assign SL   = digit_reg[11:8];
    assign SH   = digit_reg[15:12];
    assign ML   = digit_reg[19:16];
    assign MH   = digit_reg[23:20];
    assign TICK = tick_reg;
    assign WRAP = wrap_reg;
    assign DONE = done_reg;

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_reg;
    logic        lap_valid_reg;

    // Capture takes the pre-edge digits, so a coincident step or load is not seen.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            lap_reg       <= '0;
            lap_valid_reg <= 1'b0;
        end else if (LAP) begin
            lap_reg       <= digit_reg;
            lap_valid_reg <= 1'b1;
        end else if (LOAD) begin
            lap_valid_reg <= 1'b0;
        end
    end

    assign LAP_MSL   = lap_reg[3:0];
    assign LAP_MSH   = lap_reg[7:4];
    assign LAP_SL    = lap_reg[11:8];
    assign LAP_SH    = lap_reg[15:12];
    assign LAP_ML    = lap_reg[19:16];
    assign LAP_MH    = lap_reg[23:20];
    assign LAP_VALID = lap_valid_reg;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctl.sv
// Bench for bcd_stopwatch_ctl: vector table plus per-cycle scoreboard driven by a
// centisecond-integer reference model; lap checks are built with STOPWATCH_LAP_EN.
module tb_bcd_stopwatch_ctl;

    localparam int TICK_DIV     = 4;
    localparam int DIV_W        = 4;
    localparam int MIN_TENS_MAX = 5;
    localparam int MAXV         = (MIN_TENS_MAX * 10 + 10) * 6000;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        PAUSE = 1'b1;
    logic        DOWN = 1'b0;
    logic        LOAD = 1'b0;
    logic [23:0] PRESET = '0;
    logic [3:0]  MSH, MSL, SH, SL, MH, ML;
    logic        TICK, WRAP, ZERO, DONE;
`ifdef STOPWATCH_LAP_EN
    logic        LAP = 1'b0;
    logic [3:0]  LAP_MSH, LAP_MSL, LAP_SH, LAP_SL, LAP_MH, LAP_ML;
    logic        LAP_VALID;
`endif

    bcd_stopwatch_ctl #(
        .TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .MIN_TENS_MAX(MIN_TENS_MAX)
    ) dut (
        .CLK(CLK), .CLR(CLR), .PAUSE(PAUSE), .DOWN(DOWN), .LOAD(LOAD), .PRESET(PRESET),
        .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL), .MH(MH), .ML(ML),
        .TICK(TICK), .WRAP(WRAP), .ZERO(ZERO), .DONE(DONE)
`ifdef STOPWATCH_LAP_EN
        ,
        .LAP(LAP), .LAP_MSH(LAP_MSH), .LAP_MSL(LAP_MSL), .LAP_SH(LAP_SH), .LAP_SL(LAP_SL),
        .LAP_MH(LAP_MH), .LAP_ML(LAP_ML), .LAP_VALID(LAP_VALID)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] d;
        logic        tick;
        logic        wrap;
        logic        zero;
        logic        done;
    } obs_t;

    typedef struct {
        string       name;
        logic        load;
        logic [23:0] preset;
        logic        down;
        logic        pause;
        int          cycles;
        logic [23:0] exp_d;
        logic        exp_tick;
        logic        exp_wrap;
        logic        exp_done;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int   m_val  = 0;
    int   m_div  = 0;
    bit   m_done = 1'b0;

    function automatic vec_t mk(string nm, logic ld, logic [23:0] pre, logic dn, logic pz,
                                int cyc, logic [23:0] ed, logic et, logic ew, logic edn);
        vec_t v;
        v.name = nm; v.load = ld; v.preset = pre; v.down = dn; v.pause = pz;
        v.cycles = cyc; v.exp_d = ed; v.exp_tick = et; v.exp_wrap = ew; v.exp_done = edn;
        return v;
    endfunction

    function automatic logic [23:0] to_bcd(int v);
        int cs, s, m;
        cs = v % 100;
        s  = (v / 100) % 60;
        m  = v / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic int clamp_val(logic [23:0] p);
        int lim [6];
        int dg  [6];
        lim = '{9, 9, 9, 5, 9, MIN_TENS_MAX};
        for (int k = 0; k < 6; k++) begin
            dg[k] = int'(p[4*k +: 4]);
            if (dg[k] > lim[k]) dg[k] = lim[k];
        end
        return ((dg[5] * 10 + dg[4]) * 60 + dg[3] * 10 + dg[2]) * 100 + dg[1] * 10 + dg[0];
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.d = {MH, ML, SH, SL, MSH, MSL};
        o.tick = TICK; o.wrap = WRAP; o.zero = ZERO; o.done = DONE;
        return o;
    endfunction

    task automatic model_edge(input logic ld, input logic [23:0] pre, input logic dn,
                              input logic pz, output obs_t e);
        bit tk = 1'b0;
        bit wr = 1'b0;
        if (ld) begin
            m_val = clamp_val(pre); m_div = 0; m_done = 1'b0;
        end else if (!pz && !(dn && m_val == 0)) begin
            if (m_div == TICK_DIV - 1) begin
                m_div = 0;
                tk = 1'b1;
                if (dn) begin
                    m_val = m_val - 1;
                    if (m_val == 0) m_done = 1'b1;
                end else if (m_val == MAXV - 1) begin
                    m_val = 0; wr = 1'b1;
                end else begin
                    m_val = m_val + 1;
                end
            end else begin
                m_div = m_div + 1;
            end
        end
        e.d = to_bcd(m_val); e.tick = tk; e.wrap = wr; e.zero = (m_val == 0); e.done = m_done;
    endtask

    task automatic do_cycle(input logic ld, input logic [23:0] pre, input logic dn, input logic pz);
        obs_t e, a;
        LOAD = ld; PRESET = pre; DOWN = dn; PAUSE = pz;
        model_edge(ld, pre, dn, pz, e);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        a = dut_obs();
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle@%0t got d=%h t%0b w%0b z%0b dn%0b want d=%h t%0b w%0b z%0b dn%0b",
                         $time, a.d, a.tick, a.wrap, a.zero, a.done,
                         e.d, e.tick, e.wrap, e.zero, e.done);
            end
        end
    endtask

    task automatic check_val(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk("load_max",     1, 24'h595998, 0, 0,   1, 24'h595998, 0, 0, 0));
        vecs.push_back(mk("up_to_max",    0, 24'h000000, 0, 0,   4, 24'h595999, 1, 0, 0));
        vecs.push_back(mk("hold_max",     0, 24'h000000, 0, 0,   3, 24'h595999, 0, 0, 0));
        vecs.push_back(mk("wrap",         0, 24'h000000, 0, 0,   1, 24'h000000, 1, 1, 0));
        vecs.push_back(mk("post_wrap",    0, 24'h000000, 0, 0,   1, 24'h000000, 0, 0, 0));
        vecs.push_back(mk("div_to_2",     0, 24'h000000, 0, 0,   1, 24'h000000, 0, 0, 0));
        vecs.push_back(mk("pause10",      0, 24'h000000, 0, 1,  10, 24'h000000, 0, 0, 0));
        vecs.push_back(mk("resume_1",     0, 24'h000000, 0, 0,   1, 24'h000000, 0, 0, 0));
        vecs.push_back(mk("resume_2",     0, 24'h000000, 0, 0,   1, 24'h000001, 1, 0, 0));
        vecs.push_back(mk("load_100",     1, 24'h000100, 1, 0,   1, 24'h000100, 0, 0, 0));
        vecs.push_back(mk("down_first",   0, 24'h000000, 1, 0,   4, 24'h000099, 1, 0, 0));
        vecs.push_back(mk("down_to_zero", 0, 24'h000000, 1, 0, 396, 24'h000000, 1, 0, 1));
        vecs.push_back(mk("hold_zero",    0, 24'h000000, 1, 0,  20, 24'h000000, 0, 0, 1));
        vecs.push_back(mk("up_from_zero", 0, 24'h000000, 0, 0,   4, 24'h000001, 1, 0, 1));
        vecs.push_back(mk("load_clamp",   1, 24'h7AC9F3, 0, 0,   1, 24'h595993, 0, 0, 0));
        vecs.push_back(mk("near_step",    0, 24'h000000, 0, 0,   3, 24'h595993, 0, 0, 0));
        vecs.push_back(mk("load_on_step", 1, 24'h000200, 0, 0,   1, 24'h000200, 0, 0, 0));
        vecs.push_back(mk("load_1min",    1, 24'h010000, 1, 0,   1, 24'h010000, 0, 0, 0));
        vecs.push_back(mk("borrow_min",   0, 24'h000000, 1, 0,   4, 24'h005999, 1, 0, 0));
        vecs.push_back(mk("load_paused",  1, 24'h005999, 0, 1,   1, 24'h005999, 0, 0, 0));
        vecs.push_back(mk("carry_min",    0, 24'h000000, 0, 0,   4, 24'h010000, 1, 0, 0));
        vecs.push_back(mk("load_10min",   1, 24'h100000, 1, 0,   1, 24'h100000, 0, 0, 0));
        vecs.push_back(mk("borrow_mh",    0, 24'h000000, 1, 0,   4, 24'h095999, 1, 0, 0));

        // Reset must act before any clock edge.
        #3;
        check_val("reset_digits", 32'({MH, ML, SH, SL, MSH, MSL}), 32'h0);
        check_val("reset_flags", 32'({TICK, WRAP, ZERO, DONE}), 32'b0010);
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            obs_t a;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                do_cycle(vecs[i].load, vecs[i].preset, vecs[i].down, vecs[i].pause);
            end
            a = dut_obs();
            check_val({"vec_", vecs[i].name},
                      32'({a.d, a.tick, a.wrap, a.done, a.zero}),
                      32'({vecs[i].exp_d, vecs[i].exp_tick, vecs[i].exp_wrap, vecs[i].exp_done,
                           (vecs[i].exp_d == 24'd0)}));
            $display("vec %-13s cycles=%0d digits=%h tick=%0b wrap=%0b done=%0b",
                     vecs[i].name, vecs[i].cycles, a.d, a.tick, a.wrap, a.done);
        end

        // Asynchronous clear in mid-run while TICK is high.
        do_cycle(1, 24'h000316, 0, 0);
        for (int c = 0; c < 4; c++) do_cycle(0, 24'h0, 0, 0);
        check_val("clr_pre_tick", 32'(TICK), 32'h1);
        CLR = 1'b1;
        #2;
        check_val("clr_digits", 32'({MH, ML, SH, SL, MSH, MSL}), 32'h0);
        check_val("clr_flags", 32'({TICK, WRAP, ZERO, DONE}), 32'b0010);
        CLR = 1'b0;
        m_val = 0; m_div = 0; m_done = 1'b0;
        for (int c = 0; c < 4; c++) do_cycle(0, 24'h0, 0, 0);
        check_val("clr_restart", 32'({MH, ML, SH, SL, MSH, MSL}), 32'h000001);
        $display("seq async_clear digits=%h", {MH, ML, SH, SL, MSH, MSL});

`ifdef STOPWATCH_LAP_EN
        do_cycle(1, 24'h001233, 0, 0);
        for (int c = 0; c < 7; c++) do_cycle(0, 24'h0, 0, 0);
        LAP = 1'b1;
        do_cycle(0, 24'h0, 0, 0);
        LAP = 1'b0;
        check_val("lap_digits", 32'({LAP_MH, LAP_ML, LAP_SH, LAP_SL, LAP_MSH, LAP_MSL}), 32'h001234);
        check_val("lap_valid", 32'(LAP_VALID), 32'h1);
        check_val("lap_display", 32'({MH, ML, SH, SL, MSH, MSL}), 32'h001235);
        do_cycle(1, 24'h000000, 0, 0);
        check_val("lap_valid_load", 32'(LAP_VALID), 32'h0);
        $display("seq lap lap=%h", {LAP_MH, LAP_ML, LAP_SH, LAP_SL, LAP_MSH, LAP_MSL});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
